// File: rtl/oled_ssd1306_pkg.sv
// Shared types, command tables and timing helpers for the SSD1306 sequencer.
package oled_ssd1306_pkg;

    typedef enum logic [2:0] {
        ST_RES_LOW,
        ST_RES_WAIT,
        ST_SEND,
        ST_NEXT,
        ST_IDLE
    } seq_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_LOAD,
        HS_REQ,
        HS_WAIT_DONE
    } hs_state_e;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_WIN,
        PH_PIX
    } phase_e;

    localparam int INIT_LEN = 25;
    localparam int WIN_LEN  = 6;

    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    // Full-screen window: columns 0..127, pages 0..7.
    localparam logic [7:0] WIN_CMDS [WIN_LEN] = '{
        8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

    function automatic int us_to_clk(input int clk_mhz, input int us);
        return clk_mhz * us;
    endfunction

endpackage

// File: rtl/oled_ssd1306_seq_if.sv
// Byte handshake toward the SPI master plus the picture ROM read port.
interface oled_ssd1306_seq_if;
    logic       send_en;
    logic       send_dc;
    logic [7:0] send_data;
    logic       send_busy;
    logic [9:0] pic_addr;
    logic [7:0] pic_data;

    modport master (
        output send_en, send_dc, send_data, pic_addr,
        input  send_busy, pic_data
    );

    modport slave (
        input  send_en, send_dc, send_data, pic_addr,
        output send_busy, pic_data
    );
endinterface

// File: rtl/oled_spi_handshake.sv
// Moves one byte through the send_en/send_busy handshake of the slow-clocked SPI master.
// state        | meaning
// HS_IDLE      | no byte pending; waits for byte_valid_i
// HS_LOAD      | waits for the master to be idle, then captures byte and dc
// HS_REQ       | send_en high until the master reports busy
// HS_WAIT_DONE | send_en low, byte held; acks once busy drops
module oled_spi_handshake
    import oled_ssd1306_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_valid_i,
    input  logic       byte_dc_i,
    input  logic [7:0] byte_data_i,
    output logic       byte_ack_o,
    input  logic       send_busy_i,
    output logic       send_en_o,
    output logic       send_dc_o,
    output logic [7:0] send_data_o
);
    hs_state_e  state_q, state_d;
    logic       dc_q, dc_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HS_IDLE;
            dc_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HS_IDLE:      if (byte_valid_i) state_d = HS_LOAD;
            HS_LOAD:      if (!send_busy_i) state_d = HS_REQ;
            HS_REQ:       if (send_busy_i)  state_d = HS_WAIT_DONE;
            HS_WAIT_DONE: if (!send_busy_i) state_d = HS_IDLE;
            default:      state_d = HS_IDLE;
        endcase
    end

    // The master latches send_en on its own slow clock, so data must not move
    // between LOAD and the end of WAIT_DONE.
    always_comb begin
        dc_d        = dc_q;
        data_d      = data_q;
        send_en_o   = (state_q == HS_REQ);
        byte_ack_o  = (state_q == HS_WAIT_DONE) && !send_busy_i;
        send_dc_o   = dc_q;
        send_data_o = data_q;
        if (state_q == HS_LOAD && !send_busy_i) begin
            dc_d   = byte_dc_i;
            data_d = byte_data_i;
        end
    end

endmodule

// File: rtl/oled_ssd1306_seq.sv
// SSD1306 power-up, init-list and frame streaming sequencer in front of a byte SPI master.
// state       | meaning
// ST_RES_LOW  | panel reset held low for RES_LOW_US
// ST_RES_WAIT | panel reset released; settle for RES_WAIT_US
// ST_SEND     | current byte in flight through the handshake
// ST_NEXT     | advance byte index / phase
// ST_IDLE     | frame finished, waiting for frame_start_i
module oled_ssd1306_seq
    import oled_ssd1306_pkg::*;
#(
    parameter int CLK_FRE      = 50,
    parameter int RES_LOW_US   = 10,
    parameter int RES_WAIT_US  = 100,
    parameter int PIC_BYTES    = 1024,
    parameter int CONT_REFRESH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_start_i,
    oled_ssd1306_seq_if.master bus,
    output logic               oled_res_o,
    output logic               init_done_o,
    output logic               frame_done_o
);
    localparam int RES_LOW_CLKS  = us_to_clk(CLK_FRE, RES_LOW_US);
    localparam int RES_WAIT_CLKS = us_to_clk(CLK_FRE, RES_WAIT_US);
    localparam int TMR_MAX       = (RES_LOW_CLKS > RES_WAIT_CLKS) ? RES_LOW_CLKS : RES_WAIT_CLKS;
    localparam int TMR_W         = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RES_LOW_LOAD  = TMR_W'(RES_LOW_CLKS - 1);
    localparam logic [TMR_W-1:0] RES_WAIT_LOAD = TMR_W'(RES_WAIT_CLKS - 1);
    localparam logic [TMR_W-1:0] TMR_ONE       = TMR_W'(1);
    localparam logic [9:0]       INIT_LAST     = 10'(INIT_LEN - 1);
    localparam logic [9:0]       WIN_LAST      = 10'(WIN_LEN - 1);
    localparam logic [9:0]       PIX_LAST      = 10'(PIC_BYTES - 1);

    seq_state_e       state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [9:0]       idx_q, idx_d;
    logic [9:0]       addr_q, addr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             oled_res_q, oled_res_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;

    logic             byte_valid;
    logic             byte_dc;
    logic [7:0]       byte_data;
    logic             byte_ack;
    logic             frame_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RES_LOW;
            phase_q      <= PH_INIT;
            idx_q        <= '0;
            addr_q       <= '0;
            timer_q      <= RES_LOW_LOAD;
            oled_res_q   <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            timer_q      <= timer_d;
            oled_res_q   <= oled_res_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_last = (phase_q == PH_PIX) && (idx_q == PIX_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RES_LOW:  if (timer_q == '0) state_d = ST_RES_WAIT;
            ST_RES_WAIT: if (timer_q == '0) state_d = ST_SEND;
            ST_SEND:     if (byte_ack) state_d = ST_NEXT;
            ST_NEXT:     state_d = (frame_last && CONT_REFRESH == 0) ? ST_IDLE : ST_SEND;
            ST_IDLE:     if (frame_start_i) state_d = ST_SEND;
            default:     state_d = ST_RES_LOW;
        endcase
    end

    always_comb begin
        phase_d      = phase_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        timer_d      = timer_q;
        oled_res_d   = oled_res_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_RES_LOW: begin
                if (timer_q == '0) begin
                    timer_d    = RES_WAIT_LOAD;
                    oled_res_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_RES_WAIT: begin
                if (timer_q == '0) begin
                    phase_d = PH_INIT;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_NEXT: begin
                idx_d = idx_q + 10'd1;
                unique case (phase_q)
                    PH_INIT: begin
                        if (idx_q == INIT_LAST) begin
                            init_done_d = 1'b1;
                            phase_d     = PH_WIN;
                            idx_d       = '0;
                        end
                    end
                    PH_WIN: begin
                        if (idx_q == WIN_LAST) begin
                            phase_d = PH_PIX;
                            idx_d   = '0;
                            addr_d  = '0;
                        end
                    end
                    default: begin
                        // Address runs one byte ahead so the ROM output is ready at LOAD.
                        addr_d = addr_q + 10'd1;
                        if (frame_last) begin
                            frame_done_d = 1'b1;
                            phase_d      = PH_WIN;
                            idx_d        = '0;
                        end
                    end
                endcase
            end
            ST_IDLE: begin
                if (frame_start_i) begin
                    phase_d = PH_WIN;
                    idx_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_dc   = 1'b0;
        byte_data = 8'h00;
        unique case (phase_q)
            PH_INIT: byte_data = INIT_CMDS[idx_q[4:0]];
            PH_WIN:  byte_data = WIN_CMDS[idx_q[2:0]];
            default: begin
                byte_dc   = 1'b1;
                byte_data = bus.pic_data;
            end
        endcase
    end

    assign byte_valid   = (state_q == ST_SEND);
    assign bus.pic_addr = addr_q;
    assign oled_res_o   = oled_res_q;
    assign init_done_o  = init_done_q;
    assign frame_done_o = frame_done_q;

    oled_spi_handshake u_hs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid),
        .byte_dc_i    (byte_dc),
        .byte_data_i  (byte_data),
        .byte_ack_o   (byte_ack),
        .send_busy_i  (bus.send_busy),
        .send_en_o    (bus.send_en),
        .send_dc_o    (bus.send_dc),
        .send_data_o  (bus.send_data)
    );

endmodule

// File: doc/oled_ssd1306_seq.md
Name: oled_ssd1306_seq

Overview:
- Upstream command/data sequencer for the SSD1306 SPI OLED path; drives the byte-level SPI master through its send_en / send_dc / send_data / send_busy handshake.
- After reset it pulses the panel reset pin, sends a fixed init command list, and then streams frames.
- Each frame is a 6-byte address window followed by 1024 picture bytes, read from an external synchronous picture ROM (128x64, horizontal addressing).

Parameters:
- CLK_FRE, 50, input clock in MHz; used for microsecond delays.
- RES_LOW_US, 10, time oled_res is held low after reset, in us.
- RES_WAIT_US, 100, wait after oled_res is released before the first command, in us.
- PIC_BYTES, 1024, picture bytes per frame.
- CONT_REFRESH, 1, 1 = restart the frame immediately after frame_done; 0 = stop in IDLE until frame_start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse; starts a frame from IDLE (ignored elsewhere)
- pic_addr  out  10  picture ROM address
- pic_data  in  8  ROM data, valid 1 clk after pic_addr
- send_en  out  1  request to SPI master
- send_dc  out  1  0 = command, 1 = data
- send_data  out  8  byte to send
- send_busy  in  1  SPI master busy (master runs on a slower derived clock)
- oled_res  out  1  panel reset, active low
- init_done  out  1  level; high once the init list has completed
- frame_done  out  1  one-cycle pulse after the last picture byte completes

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: send_en=0, send_dc=0, send_data=0, pic_addr=0, oled_res=0, init_done=0, frame_done=0, state=RES_LOW, byte index=0.
- Reset mid-operation: an in-flight byte is abandoned. The sequence restarts from RES_LOW; the SPI master is not reset by this block.
- States:
  - RES_LOW: oled_res=0; count CLK_FRE*RES_LOW_US clks, then go to RES_WAIT.
  - RES_WAIT: oled_res=1; count CLK_FRE*RES_WAIT_US clks, then go to LOAD with phase=INIT, idx=0.
  - LOAD: wait for send_busy==0. Present the byte for phase/idx on send_data/send_dc. For PIX, pic_addr=idx was issued one clk earlier, so pic_data is registered here. Go to REQ.
  - REQ: send_en=1, data/dc held stable; stay until send_busy==1, then go to WAIT_DONE.
  - WAIT_DONE: send_en=0, data/dc held; stay until send_busy==0, then go to NEXT.
  - NEXT: advance idx within the phase.
    - End of INIT (25 bytes): init_done=1, then phase WIN.
    - End of WIN (6 bytes): phase PIX, idx=0.
    - End of PIX (idx==PIC_BYTES-1): pulse frame_done, then go to WIN if CONT_REFRESH else IDLE.
  - IDLE: hold outputs; frame_start moves to LOAD with phase=WIN.
- send_en must stay high until busy is seen. This is required because the master samples send_en on its slow clock. The block has no timeout; it waits indefinitely.
- send_dc: 0 for the INIT and WIN phases, 1 for PIX.
- INIT list, in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- WIN list: 21 00 7F 22 00 07.
- pic_addr:
  - Is 10 bits and wraps 1023->0 naturally at the frame end.
  - Updates in NEXT (PIX) so that data is ready at the next LOAD.
  - Is set to 0 on entering PIX.
- Delay counters are sized for CLK_FRE*RES_WAIT_US, at least 13 bits at defaults.
- frame_start while not IDLE: ignored. rst and frame_start together: rst wins.

Decomposition:
- Package oled_ssd1306_pkg holds:
  - state and phase enums;
  - INIT_LEN=25 and WIN_LEN=6;
  - INIT_CMDS and WIN_CMDS constant byte arrays;
  - the us-to-clk conversion function.
- One sub-module is natural: oled_spi_handshake, the LOAD/REQ/WAIT_DONE byte-handshake FSM, with a byte-valid input and a byte-ack output. Sequencing stays in the top.

Test Plan:
- Reset release, CLK_FRE=50 -> oled_res low for 500 clks, then high; first send_en no earlier than 5000 clks after release; send_data=0xAE, send_dc=0.
- Slow master model (busy asserted 7 clks after en, lasting 160 clks) -> send_en held until busy; exactly 25 command bytes match the INIT list; init_done rises after AF completes.
- Continue with CONT_REFRESH=0 -> WIN bytes 21 00 7F 22 00 07 with dc=0; then 1024 data bytes with dc=1, each equal to ROM[addr] (ROM = addr[7:0]^0x5A); frame_done pulses once; block enters IDLE.
- frame_start pulse in IDLE -> new WIN then PIX; pic_addr starts at 0; frame_start during PIX is ignored (byte count stays 1024).
- rst asserted mid-PIX (byte 300) while busy=1 -> next clk oled_res=0, send_en=0, init_done=0; full sequence restarts; first request waits for busy=0.
- CONT_REFRESH=1 -> back-to-back frames, one frame_done per 1030 transferred bytes.
